mem_access_ctrl: RTL

Initiator for the CPU data-memory port. It accepts one load or store request at a time from the MEM stage and drives the word-organised data memory's Addr/Data_input/Mode/str/sel inputs. Sub-word stores are done as a read-modify-write of the containing word. Load data is extracted from the returned word and sign- or zero-extended. The block sits between the pipeline MEM stage and the data memory; that memory's read path is combinational and it writes on the rising edge.

---
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Purpose: single-outstanding load/store initiator for a word-organised data memory, RMW for sub-word stores.
// Latency: accept->resp 1 (error), 2 (load, word store), 3 (sub-word store) cycles.
// Backpressure: req_ready low while busy (requests ignored); no response backpressure.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_mode,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [1:0]            mem_mode,
    output logic                  mem_str,
    output logic                  mem_sel,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t                state;
    logic                  we_q;
    logic [1:0]            mode_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_q;
    logic                  req_err;

    assign req_err = (req_mode == 2'b11) ||
                     (req_mode == 2'b01 && req_addr[0]) ||
                     (req_mode == 2'b10 && req_addr[1:0] != 2'b00);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] mode,
                                            input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (mode)
            2'b00:   extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] mode, input logic [1:0] lo);
        logic [31:0] m;
        m = w;
        case (mode)
            2'b00:   m[{lo, 3'b000} +: 8] = d[7:0];
            2'b01:   m[{lo[1], 4'b0000} +: 16] = d[15:0];
            default: m = d;
        endcase
        merge = m;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            mode_q     <= '0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        mode_q    <= req_mode;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= RSP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && req_mode == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    word_q <= mem_rdata;
                    if (we_q) begin
                        state <= WR;
                    end else begin
                        state      <= RSP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extract(mem_rdata, mode_q, addr_q[1:0], uns_q);
                    end
                end
                WR: begin
                    state      <= RSP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated by clr so a reset landing in WR never writes.
    always_comb begin
        mem_mode  = 2'b10;
        mem_sel   = 1'b0;
        mem_str   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == RD || state == WR) begin
            mem_sel  = !clr;
            mem_addr = addr_q;
        end
        if (state == WR) begin
            mem_str   = !clr;
            mem_wdata = merge(word_q, wdata_q, mode_q, addr_q[1:0]);
        end
    end

endmodule
